// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, message FSM state codes and frame sizing helpers shared by the UART transmitter
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_FRAME = 2'b10,
    ST_DONE  = 2'b11
  } state_t;
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction
endpackage

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: one UART frame per valid&ready (clk, reset, valid, data in; ready, frame_end pulse, txd out), ready also on the frame_end cycle for back-to-back frames
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DIV = 10,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       frame_end,
  output logic       txd
);
  localparam int FB = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(FB);
  logic active, par;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [FB-1:0] frame, sh;
  always_comb begin
    par = ^(data & 8'((1 << DATA_BITS) - 1)) ^ (PARITY == PAR_ODD);
    frame = '1;
    frame[0] = 1'b0;
    frame[DATA_BITS:1] = data[DATA_BITS-1:0];
    if (PARITY != PAR_NONE) frame[DATA_BITS+1] = par;
  end
  assign frame_end = active && cnt == CW'(DIV - 1) && bit_idx == BW'(FB - 1);
  assign ready = !active || frame_end;
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '1;
      txd <= 1'b1;
    end else if (valid && ready) begin
      active <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      sh <= {1'b1, frame[FB-1:1]};
      txd <= frame[0];
    end else if (active) begin
      if (cnt == CW'(DIV - 1)) begin
        cnt <= '0;
        bit_idx <= bit_idx + 1'b1;
        sh <= {1'b1, sh[FB-1:1]};
        txd <= frame_end | sh[0];
        active <= !frame_end;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: sends msg (char 0 in top byte, len clamped to N_BYTES) as back-to-back UART frames on txd; start/repeat_en in, busy/done/led status out
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD = 9600,
  parameter int N_BYTES = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY = PAR_NONE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [8*N_BYTES-1:0]         msg,
  input  logic [$clog2(N_BYTES+1)-1:0] len,
  input  logic                         repeat_en,
  output logic                         txd,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   led
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int LW = $clog2(N_BYTES + 1);
  if (DIV < 2) begin : g_div_chk
    $error("uart_msg_tx: CLK_HZ/BAUD must be at least 2");
  end
  state_t state;
  logic [8*N_BYTES-1:0] msg_r;
  logic [LW-1:0] len_r, len_c, idx, idx_n, sel;
  logic [LW+2:0] shamt;
  logic [7:0] ch;
  logic rep_r, valid_r, done_st, ready, frame_end, more, ser_valid;
  always_comb begin
    len_c = (len > LW'(N_BYTES)) ? LW'(N_BYTES) : len;
    idx_n = idx + 1'b1;
    more = idx_n < len_r;
    sel = frame_end ? idx_n : idx;
    shamt = {LW'(N_BYTES - 1) - sel, 3'b000};
    ch = 8'(msg_r >> shamt);
    ser_valid = ready && (valid_r || (state == ST_FRAME && frame_end && more));
  end
  assign led = {state, done_st, busy};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      msg_r <= '0;
      len_r <= '0;
      idx <= '0;
      rep_r <= 1'b0;
      valid_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      done_st <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          msg_r <= msg;
          len_r <= len_c;
          rep_r <= repeat_en;
          idx <= '0;
          busy <= 1'b1;
          done <= len_c == '0;
          done_st <= len_c == '0;
          state <= (len_c == '0) ? ST_DONE : ST_LOAD;
        end
        ST_LOAD: begin
          valid_r <= 1'b1;
          state <= ST_FRAME;
        end
        ST_FRAME: if (frame_end) begin
          if (more) begin
            idx <= idx_n;
          end else begin
            done <= 1'b1;
            done_st <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          rep_r <= rep_r & repeat_en;
          idx <= '0;
          if (rep_r && repeat_en) begin
            done <= len_r == '0;
            state <= (len_r == '0) ? ST_DONE : ST_LOAD;
          end else begin
            busy <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
  uart_tx_frame #(
    .DIV(DIV),
    .DATA_BITS(DATA_BITS),
    .PARITY(PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_frame (
    .clk(clk),
    .reset(reset),
    .valid(ser_valid),
    .data(ch),
    .ready(ready),
    .frame_end(frame_end),
    .txd(txd)
  );
endmodule
